ts_stream_demux: RTL and testbench
==================================

Name: ts_stream_demux

Overview:
- Receive-side counterpart of the 4-source TS multiplexer.
- Input is a byte stream of 192-byte frames: a 4-byte routing header followed by a 188-byte TS packet, with P_SYNC marking the 0x47 sync byte at frame offset 4.
- The block locks to frame timing, strips and reports the header, and routes each 188-byte packet to one of 4 channel outputs, selected by the header channel field.
- Sits at the receiving end of the inter-board/inter-FPGA TS link, ahead of the per-channel FIFOs.

Parameters:
- PKT_LEN, 188, TS packet bytes forwarded per frame (sync byte included).
- HDR_LEN, 4, header bytes preceding the sync byte (fixed at 4; the header register is 32 bits).
- SYNC_BYTE, 8'h47, required value of the byte flagged by P_SYNC_IN.

Ports:
- SYS_CLK  in  1  single clock for all logic.
- RST  in  1  synchronous, active-high reset.
- DATA_IN  in  8  stream byte.
- D_VALID_IN  in  1  DATA_IN qualifier; gaps allowed anywhere in a frame.
- P_SYNC_IN  in  1  high with the valid byte at frame offset 4.
- DATA_OUT  out  8  forwarded payload byte, shared by all channels.
- D_VALID_OUT  out  4  one-hot; bit n qualifies DATA_OUT for channel n.
- P_SYNC_OUT  out  1  high with the first forwarded byte (0x47) of each packet.
- CH_OUT  out  2  channel of the packet currently being forwarded.
- HEADER_OUT  out  32  last captured header; first-received byte in [31:24].
- HEADER_VALID  out  1  1-cycle pulse when HEADER_OUT updates.
- PKT_ABORT  out  4  1-cycle pulse on channel n when its packet is truncated.
- SYNC_ERR  out  1  1-cycle pulse on each sync violation.
- LOCKED  out  1  high while frame alignment is held.
- state_mon  out  2  current FSM state.

Behaviour:
- Reset:
  - All outputs are 0.
  - FSM returns to HUNT, counters and history clear.
  - Reset mid-packet gives no PKT_ABORT; outputs are 0 the cycle after RST is sampled.
- History: 4-byte shift register hist[3:0] loads on every D_VALID_IN byte; hist[3] is the oldest.
- Good sync: D_VALID_IN && P_SYNC_IN && DATA_IN == SYNC_BYTE. On a good sync:
  - HEADER_OUT <= {hist[3], hist[2], hist[1], hist[0]}.
  - HEADER_VALID pulses.
  - The channel register is set to hist[3][1:0]; hist[3][7:2] is reserved and ignored.
- byte_cnt (8 bits) counts valid bytes only. It is set to 5 on the byte after a good sync and wraps 191 -> 0.
- FSM states (2-bit encoding):
  - HUNT = 0:
    - Drop all bytes and hold LOCKED = 0.
    - A good sync -> PAYLOAD, and that sync byte is forwarded.
  - PAYLOAD = 1:
    - Forward valid bytes at offsets 4..191 on DATA_OUT with D_VALID_OUT[ch]; P_SYNC_OUT on offset 4.
    - After offset 191 -> HEADER.
  - HEADER = 2:
    - Absorb offsets 0..3; nothing is forwarded.
    - At expected offset 4: a good sync -> PAYLOAD with the new header and channel.
    - Otherwise: SYNC_ERR pulses, LOCKED <= 0, and the FSM -> HUNT; that byte is discarded.
- LOCKED is set on the first good sync and cleared on any SYNC_ERR.
- Early sync: P_SYNC_IN arrives in PAYLOAD, or in HEADER at an offset other than 4.
  - SYNC_ERR pulses and PKT_ABORT[ch] pulses when the current packet is incomplete.
  - If it is a good sync, the block realigns immediately: header captured, offset 4, PAYLOAD.
  - Otherwise -> HUNT.
- P_SYNC_IN with a wrong data value is always an error and is never forwarded.
- Latency: all outputs are registered; a forwarded byte appears exactly 1 cycle after it is sampled. Input gaps are reproduced as output gaps.
- Exactly PKT_LEN bytes are forwarded per non-aborted packet.

Optional Feature:
- Macro: SYNC_ERR_CNT_EN.
- Defined:
  - Adds output ERR_CNT [15:0], which increments on each SYNC_ERR and saturates at 16'hFFFF.
  - Cleared only by RST.
- Undefined: the port is absent and no counter logic is built.

Decomposition:
- Shared package/defines:
  - FSM state constants.
  - SYNC_BYTE, PKT_LEN, HDR_LEN and the frame length 192.
  - Header field positions (channel = byte0[1:0]).
  - The multiplexer should use the same constants.
- One natural sub-module, ts_sync_tracker: history register, byte_cnt, good-sync/error detection and LOCKED.
- The top level keeps the routing and output registers.

Test Plan:
- Single frame: header 02 AA BB CC, then 0x47 + 187 bytes -> HEADER_OUT = 0x02AABBCC and HEADER_VALID pulses once; 188 bytes on D_VALID_OUT = 4'b0100 with P_SYNC_OUT on the 0x47; LOCKED = 1.
- Back-to-back frames for channels 0, 1, 2, 3 with random D_VALID_IN gaps -> each packet goes to the correct one-hot bit, 188 bytes each, byte-exact; no SYNC_ERR.
- Second frame's offset-4 byte = 0x46 with P_SYNC_IN -> SYNC_ERR pulses, LOCKED = 0, nothing forwarded; recovery on the next good sync.
- Good sync injected at payload offset 100 of a channel-1 packet -> PKT_ABORT = 4'b0010 and SYNC_ERR pulse; the new packet is forwarded from that byte with the new header.
- RST asserted at payload offset 50 -> all outputs 0 the next cycle, FSM in HUNT, no PKT_ABORT.
- With SYNC_ERR_CNT_EN: 3 corrupted syncs -> ERR_CNT = 3. Force the counter to 16'hFFFF plus one more error -> it stays at 16'hFFFF.

Source files
------------

// File: rtl/ts_stream_demux_pkg.sv
// rtl/ts_stream_demux_pkg.sv - shared frame constants and FSM state type for the TS link demux/mux
//
// Purpose: one place for the TS link frame geometry, the sync byte value,
// the position of the channel field inside the routing header, and the
// receive FSM state encoding. The transmit multiplexer uses the same constants.
// Ports: none (package).
package ts_stream_demux_pkg;

  localparam int PKT_LEN   = 188;                 // TS packet bytes, sync byte included
  localparam int HDR_LEN   = 4;                   // routing header bytes ahead of the sync byte
  localparam int FRAME_LEN = HDR_LEN + PKT_LEN;   // 192 bytes per link frame

  localparam logic [7:0] SYNC_BYTE = 8'h47;

  // Frame offsets as seen by the 8-bit byte counter.
  localparam logic [7:0] SYNC_OFS          = 8'(HDR_LEN);
  localparam logic [7:0] FIRST_PAYLOAD_OFS = 8'(HDR_LEN + 1);
  localparam logic [7:0] LAST_OFS          = 8'(FRAME_LEN - 1);

  // Channel field = header byte0[1:0]; byte0 is the first received byte and
  // lands in [31:24] of the 32-bit header word. byte0[7:2] is reserved.
  localparam int CH_MSB = 25;
  localparam int CH_LSB = 24;

  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_HEADER  = 2'd2
  } state_e;

  function automatic logic [3:0] ch_onehot(input logic [1:0] ch);
    return 4'b0001 << ch;
  endfunction

endpackage

// File: rtl/ts_stream_demux_sync_tracker.sv
// rtl/ts_stream_demux_sync_tracker.sv - byte history, frame offset counter, sync checking and lock flag
//
// Purpose: tracks frame timing of the incoming link byte stream.
// Ports:
//   clk_i, rst_i     clock, synchronous active-high reset
//   data_i, valid_i  input byte and its qualifier
//   sync_i           P_SYNC flag from the link
//   state_i          current receive FSM state (decides which syncs are early)
//   header_o         last four valid bytes, oldest in [31:24]
//   byte_cnt_o       frame offset of the next valid byte
//   good_sync_o      valid flagged byte carrying SYNC_BYTE
//   sync_err_o       sync violation on this cycle (combinational)
//   locked_o         registered frame-lock flag
module ts_sync_tracker
  import ts_stream_demux_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  data_i,
  input  logic        valid_i,
  input  logic        sync_i,
  input  state_e      state_i,
  output logic [31:0] header_o,
  output logic [7:0]  byte_cnt_o,
  output logic        good_sync_o,
  output logic        sync_err_o,
  output logic        locked_o
);

  logic [3:0][7:0] hist_q;
  logic [7:0]      byte_cnt_q;
  logic [7:0]      byte_cnt_d;
  logic            locked_q;
  logic            locked_d;
  logic            flagged;
  logic            at_sync_ofs;
  logic            early;
  logic            missing;

  assign flagged     = valid_i && sync_i;
  assign good_sync_o = flagged && (data_i == SYNC_BYTE);
  assign at_sync_ofs = (byte_cnt_q == SYNC_OFS);

  // A flag anywhere inside a packet or inside the header gap is early.
  assign early   = flagged && ((state_i == ST_PAYLOAD) ||
                               ((state_i == ST_HEADER) && !at_sync_ofs));
  // While aligned, the byte at offset 4 must be a good sync.
  assign missing = valid_i && (state_i == ST_HEADER) && at_sync_ofs && !good_sync_o;
  // A flagged byte with the wrong value is an error in every state.
  assign sync_err_o = early || missing || (flagged && !good_sync_o);

  always_comb begin
    byte_cnt_d = byte_cnt_q;
    if (good_sync_o) begin
      byte_cnt_d = FIRST_PAYLOAD_OFS;
    end else if (valid_i) begin
      byte_cnt_d = (byte_cnt_q == LAST_OFS) ? 8'd0 : byte_cnt_q + 8'd1;
    end
  end

  // A good sync that realigns after an early sync keeps the block locked.
  always_comb begin
    locked_d = locked_q;
    if (good_sync_o) begin
      locked_d = 1'b1;
    end else if (sync_err_o) begin
      locked_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hist_q     <= '0;
      byte_cnt_q <= '0;
      locked_q   <= 1'b0;
    end else begin
      if (valid_i) begin
        hist_q <= {hist_q[2:0], data_i};
      end
      byte_cnt_q <= byte_cnt_d;
      locked_q   <= locked_d;
    end
  end

  assign header_o   = hist_q;
  assign byte_cnt_o = byte_cnt_q;
  assign locked_o   = locked_q;

endmodule

// File: rtl/ts_stream_demux.sv
// rtl/ts_stream_demux.sv - 4-channel TS demultiplexer for the inter-board TS link
//
// Purpose: locks to 192-byte link frames (4-byte routing header + 188-byte
// TS packet), reports each header and routes each packet to one of four
// channel outputs chosen by header byte0[1:0]. All outputs are registered.
// Optional feature macro: SYNC_ERR_CNT_EN adds ERR_CNT, a saturating count
// of sync errors.
// Ports:
//   SYS_CLK, RST               clock, synchronous active-high reset
//   DATA_IN, D_VALID_IN        input byte stream with gaps allowed
//   P_SYNC_IN                  marks the sync byte at frame offset 4
//   DATA_OUT, D_VALID_OUT      forwarded byte, one-hot channel qualifier
//   P_SYNC_OUT, CH_OUT         first byte of packet, current packet channel
//   HEADER_OUT, HEADER_VALID   last captured header and its update pulse
//   PKT_ABORT, SYNC_ERR        truncated-packet pulse per channel, sync error pulse
//   LOCKED, state_mon          frame lock flag, FSM state
//   ERR_CNT                    sync error count (SYNC_ERR_CNT_EN only)
module ts_stream_demux
  import ts_stream_demux_pkg::*;
(
  input  logic        SYS_CLK,
  input  logic        RST,
  input  logic [7:0]  DATA_IN,
  input  logic        D_VALID_IN,
  input  logic        P_SYNC_IN,
  output logic [7:0]  DATA_OUT,
  output logic [3:0]  D_VALID_OUT,
  output logic        P_SYNC_OUT,
  output logic [1:0]  CH_OUT,
  output logic [31:0] HEADER_OUT,
  output logic        HEADER_VALID,
  output logic [3:0]  PKT_ABORT,
  output logic        SYNC_ERR,
  output logic        LOCKED,
  output logic [1:0]  state_mon
`ifdef SYNC_ERR_CNT_EN
  ,
  output logic [15:0] ERR_CNT
`endif
);

  state_e      state_q, state_d;
  logic [7:0]  data_q, data_d;
  logic [3:0]  dvalid_q, dvalid_d;
  logic        psync_q;
  logic [1:0]  ch_q, ch_d;
  logic [31:0] hdr_q, hdr_d;
  logic        hvalid_q;
  logic [3:0]  abort_q, abort_d;
  logic        serr_q;
  logic        fwd;

  logic [31:0] header;
  logic [7:0]  byte_cnt;
  logic        good_sync;
  logic        sync_err;
  logic        locked;

  ts_sync_tracker u_tracker (
    .clk_i       (SYS_CLK),
    .rst_i       (RST),
    .data_i      (DATA_IN),
    .valid_i     (D_VALID_IN),
    .sync_i      (P_SYNC_IN),
    .state_i     (state_q),
    .header_o    (header),
    .byte_cnt_o  (byte_cnt),
    .good_sync_o (good_sync),
    .sync_err_o  (sync_err),
    .locked_o    (locked)
  );

  always_comb begin
    state_d = state_q;
    fwd     = 1'b0;
    abort_d = '0;
    if (D_VALID_IN) begin
      case (state_q)
        ST_HUNT: begin
          if (good_sync) begin
            state_d = ST_PAYLOAD;
            fwd     = 1'b1;
          end
        end
        ST_PAYLOAD: begin
          if (P_SYNC_IN) begin
            // Any flag inside a packet truncates it; a good one starts the next.
            abort_d = ch_onehot(ch_q);
            state_d = good_sync ? ST_PAYLOAD : ST_HUNT;
            fwd     = good_sync;
          end else begin
            fwd = 1'b1;
            if (byte_cnt == LAST_OFS) begin
              state_d = ST_HEADER;
            end
          end
        end
        ST_HEADER: begin
          if (good_sync) begin
            state_d = ST_PAYLOAD;
            fwd     = 1'b1;
          end else if (sync_err) begin
            state_d = ST_HUNT;
          end
        end
        default: state_d = ST_HUNT;
      endcase
    end

    // Every good sync starts a packet, so header and channel follow it directly.
    ch_d     = good_sync ? header[CH_MSB:CH_LSB] : ch_q;
    hdr_d    = good_sync ? header : hdr_q;
    data_d   = fwd ? DATA_IN : data_q;
    dvalid_d = fwd ? ch_onehot(ch_d) : 4'b0000;
  end

  always_ff @(posedge SYS_CLK) begin
    if (RST) begin
      state_q  <= ST_HUNT;
      data_q   <= '0;
      dvalid_q <= '0;
      psync_q  <= 1'b0;
      ch_q     <= '0;
      hdr_q    <= '0;
      hvalid_q <= 1'b0;
      abort_q  <= '0;
      serr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      dvalid_q <= dvalid_d;
      psync_q  <= good_sync;
      ch_q     <= ch_d;
      hdr_q    <= hdr_d;
      hvalid_q <= good_sync;
      abort_q  <= abort_d;
      serr_q   <= sync_err;
    end
  end

`ifdef SYNC_ERR_CNT_EN
  logic [15:0] err_cnt_q;

  always_ff @(posedge SYS_CLK) begin
    if (RST) begin
      err_cnt_q <= '0;
    end else if (sync_err && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign ERR_CNT = err_cnt_q;
`endif

  assign DATA_OUT     = data_q;
  assign D_VALID_OUT  = dvalid_q;
  assign P_SYNC_OUT   = psync_q;
  assign CH_OUT       = ch_q;
  assign HEADER_OUT   = hdr_q;
  assign HEADER_VALID = hvalid_q;
  assign PKT_ABORT    = abort_q;
  assign SYNC_ERR     = serr_q;
  assign LOCKED       = locked;
  assign state_mon    = state_q;

endmodule

// File: tb/tb_ts_stream_demux.sv
// tb/tb_ts_stream_demux.sv - scoreboard testbench for ts_stream_demux
module tb_ts_stream_demux;

  logic        SYS_CLK = 1'b0;
  logic        RST = 1'b1;
  logic [7:0]  DATA_IN = 8'h00;
  logic        D_VALID_IN = 1'b0;
  logic        P_SYNC_IN = 1'b0;
  logic [7:0]  DATA_OUT;
  logic [3:0]  D_VALID_OUT;
  logic        P_SYNC_OUT;
  logic [1:0]  CH_OUT;
  logic [31:0] HEADER_OUT;
  logic        HEADER_VALID;
  logic [3:0]  PKT_ABORT;
  logic        SYNC_ERR;
  logic        LOCKED;
  logic [1:0]  state_mon;
`ifdef SYNC_ERR_CNT_EN
  logic [15:0] ERR_CNT;
`endif

  ts_stream_demux dut (
    .SYS_CLK      (SYS_CLK),
    .RST          (RST),
    .DATA_IN      (DATA_IN),
    .D_VALID_IN   (D_VALID_IN),
    .P_SYNC_IN    (P_SYNC_IN),
    .DATA_OUT     (DATA_OUT),
    .D_VALID_OUT  (D_VALID_OUT),
    .P_SYNC_OUT   (P_SYNC_OUT),
    .CH_OUT       (CH_OUT),
    .HEADER_OUT   (HEADER_OUT),
    .HEADER_VALID (HEADER_VALID),
    .PKT_ABORT    (PKT_ABORT),
    .SYNC_ERR     (SYNC_ERR),
    .LOCKED       (LOCKED),
    .state_mon    (state_mon)
`ifdef SYNC_ERR_CNT_EN
    ,
    .ERR_CNT      (ERR_CNT)
`endif
  );

  always #5 SYS_CLK = ~SYS_CLK;

  int checks = 0;
  int errors = 0;
  int serr_total = 0;
  bit gaps_en = 1'b0;

  // Expected forwarded bytes: {psync, channel, data}, in link order.
  logic [10:0] exp_byte_q[$];
  logic [31:0] exp_hdr_q[$];
  logic [3:0]  exp_abort_q[$];
  int          exp_serr_q[$];

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic void exp_byte(input logic [1:0] ch, input logic [7:0] d, input logic ps);
    exp_byte_q.push_back({ps, ch, d});
  endfunction

  function automatic logic [31:0] rand_hdr(input logic [1:0] ch);
    logic [5:0] rsv;
    rsv = 6'($urandom);
    return {rsv, ch, 24'($urandom)};
  endfunction

  // Monitor: compares every DUT output event against the scoreboard queues.
  always @(negedge SYS_CLK) begin
    logic [10:0] e;
    if (D_VALID_OUT != 4'b0000) begin
      check("byte_expected", 32'(exp_byte_q.size() > 0), 32'd1);
      if (exp_byte_q.size() > 0) begin
        e = exp_byte_q.pop_front();
        check("d_valid_out", 32'(D_VALID_OUT), 32'(4'b0001 << e[9:8]));
        check("data_out", 32'(DATA_OUT), 32'(e[7:0]));
        check("p_sync_out", 32'(P_SYNC_OUT), 32'(e[10]));
        check("ch_out", 32'(CH_OUT), 32'(e[9:8]));
      end
    end
    if (HEADER_VALID) begin
      check("header_expected", 32'(exp_hdr_q.size() > 0), 32'd1);
      if (exp_hdr_q.size() > 0) check("header_out", HEADER_OUT, exp_hdr_q.pop_front());
    end
    if (PKT_ABORT != 4'b0000) begin
      check("abort_expected", 32'(exp_abort_q.size() > 0), 32'd1);
      if (exp_abort_q.size() > 0) check("pkt_abort", 32'(PKT_ABORT), 32'(exp_abort_q.pop_front()));
    end
    if (SYNC_ERR) begin
      check("sync_err_expected", 32'(exp_serr_q.size() > 0), 32'd1);
      if (exp_serr_q.size() > 0) void'(exp_serr_q.pop_front());
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic [7:0] d, input logic s);
    if (gaps_en) begin
      repeat ($urandom_range(0, 2)) begin
        @(negedge SYS_CLK);
        D_VALID_IN = 1'b0;
        P_SYNC_IN  = 1'b0;
        DATA_IN    = 8'($urandom);
      end
    end
    @(negedge SYS_CLK);
    DATA_IN    = d;
    D_VALID_IN = 1'b1;
    P_SYNC_IN  = s;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge SYS_CLK);
      D_VALID_IN = 1'b0;
      P_SYNC_IN  = 1'b0;
    end
  endtask

  task automatic send_header(input logic [31:0] h);
    for (int i = 3; i >= 0; i--) drive(h[8*i +: 8], 1'b0);
  endtask

  // Sync byte plus n random payload bytes, all expected on channel ch.
  task automatic send_packet(input logic [1:0] ch, input int n);
    logic [7:0] b;
    exp_byte(ch, 8'h47, 1'b1);
    drive(8'h47, 1'b1);
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom);
      exp_byte(ch, b, 1'b0);
      drive(b, 1'b0);
    end
  endtask

  task automatic good_frame(input logic [31:0] h);
    exp_hdr_q.push_back(h);
    send_header(h);
    send_packet(h[25:24], 187);
  endtask

  task automatic bad_sync_frame(input logic [31:0] h);
    send_header(h);
    exp_serr_q.push_back(1);
    serr_total++;
    drive(8'h46, 1'b1);
    for (int i = 0; i < 187; i++) drive(8'($urandom), 1'b0);
  endtask

  // New frame starts at payload offset 100: its header is bytes 96..99 of the old packet.
  task automatic early_sync(input logic [31:0] h_old, input logic [31:0] h_new);
    exp_hdr_q.push_back(h_old);
    send_header(h_old);
    send_packet(h_old[25:24], 91);
    for (int i = 3; i >= 0; i--) begin
      exp_byte(h_old[25:24], h_new[8*i +: 8], 1'b0);
      drive(h_new[8*i +: 8], 1'b0);
    end
    exp_abort_q.push_back(4'b0001 << h_old[25:24]);
    exp_serr_q.push_back(1);
    serr_total++;
    exp_hdr_q.push_back(h_new);
    send_packet(h_new[25:24], 187);
  endtask

  task automatic reset_mid_packet(input logic [31:0] h);
    exp_hdr_q.push_back(h);
    send_header(h);
    send_packet(h[25:24], 45);
    @(negedge SYS_CLK);
    DATA_IN    = 8'($urandom);
    D_VALID_IN = 1'b1;
    P_SYNC_IN  = 1'b0;
    RST        = 1'b1;
    @(negedge SYS_CLK);
    check("rst_d_valid_out", 32'(D_VALID_OUT), 32'd0);
    check("rst_data_out", 32'(DATA_OUT), 32'd0);
    check("rst_header_out", HEADER_OUT, 32'd0);
    check("rst_pkt_abort", 32'(PKT_ABORT), 32'd0);
    check("rst_locked", 32'(LOCKED), 32'd0);
    check("rst_state", 32'(state_mon), 32'd0);
    check("rst_ch_out", 32'(CH_OUT), 32'd0);
    RST        = 1'b0;
    D_VALID_IN = 1'b0;
    serr_total = 0;
    idle(3);
    check("post_rst_pkt_abort", 32'(PKT_ABORT), 32'd0);
  endtask

  initial begin
    logic [7:0] b;
    RST = 1'b1;
    idle(4);
    check("reset_d_valid_out", 32'(D_VALID_OUT), 32'd0);
    check("reset_p_sync_out", 32'(P_SYNC_OUT), 32'd0);
    check("reset_header_valid", 32'(HEADER_VALID), 32'd0);
    check("reset_sync_err", 32'(SYNC_ERR), 32'd0);
    check("reset_locked", 32'(LOCKED), 32'd0);
    check("reset_state", 32'(state_mon), 32'd0);
    RST = 1'b0;
    idle(2);

    gaps_en = 1'b0;
    good_frame(32'h02AABBCC);
    idle(3);
    check("single_locked", 32'(LOCKED), 32'd1);
    check("single_header", HEADER_OUT, 32'h02AABBCC);
    check("single_state_header", 32'(state_mon), 32'd2);

    gaps_en = 1'b1;
    for (int c = 0; c < 4; c++) good_frame(rand_hdr(2'(c)));
    idle(3);
    check("b2b_locked", 32'(LOCKED), 32'd1);

    bad_sync_frame(rand_hdr(2'd1));
    idle(3);
    check("badsync_locked", 32'(LOCKED), 32'd0);
    check("badsync_state_hunt", 32'(state_mon), 32'd0);

    good_frame(rand_hdr(2'd3));
    idle(3);
    check("recover_locked", 32'(LOCKED), 32'd1);

    early_sync(rand_hdr(2'd1), rand_hdr(2'd2));
    idle(3);
    check("early_locked", 32'(LOCKED), 32'd1);

    for (int i = 0; i < 3; i++) good_frame(rand_hdr(2'($urandom)));
`ifdef SYNC_ERR_CNT_EN
    idle(3);
    check("err_cnt_run", 32'(ERR_CNT), 32'(serr_total));
`endif

    reset_mid_packet(rand_hdr(2'd0));

    for (int i = 0; i < 3; i++) begin
      b = 8'($urandom);
      if (b == 8'h47) b = 8'h48;
      exp_serr_q.push_back(1);
      serr_total++;
      drive(b, 1'b1);
    end
    idle(3);
    check("hunt_errs_state", 32'(state_mon), 32'd0);
`ifdef SYNC_ERR_CNT_EN
    check("err_cnt_three", 32'(ERR_CNT), 32'd3);
    @(negedge SYS_CLK);
    force dut.err_cnt_q = 16'hFFFF;
    @(negedge SYS_CLK);
    release dut.err_cnt_q;
    exp_serr_q.push_back(1);
    drive(8'h00, 1'b1);
    idle(3);
    check("err_cnt_saturate", 32'(ERR_CNT), 32'h0000FFFF);
`endif

    good_frame(rand_hdr(2'd2));
    idle(10);
    check("bytes_left", 32'(exp_byte_q.size()), 32'd0);
    check("headers_left", 32'(exp_hdr_q.size()), 32'd0);
    check("aborts_left", 32'(exp_abort_q.size()), 32'd0);
    check("sync_errs_left", 32'(exp_serr_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
